// File: rtl/multi_heater_control.sv
// Multi-channel bang-bang heater controller: per-channel IIR-filtered ADC, setpoint/hysteresis control, settle and fault.
// Optional HEATER_RUNAWAY_EN adds a per-channel watchdog on continuous heater-on time.
//
// state  | meaning
// OFF    | idle, heater off, no over-temp check
// SETTLE | heater off for SETTLE_CYC cycles after a command
// HEAT   | one-shot heat until filt reaches target
// DONE   | one-shot complete, at_target held
// HOLD   | hysteresis regulation around target
// FAULT  | sticky over-temp / runaway, left only by an OFF command
module multi_heater_control #(
   parameter int CHANNELS    = 2,
   parameter int ADC_W       = 12,
   parameter int FILT_SHIFT  = 4,
   parameter int SETTLE_CYC  = 100,
   parameter int RUNAWAY_CYC = 2**24
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [CHANNELS*ADC_W-1:0] adc_code_i,
   input  logic [ADC_W-1:0]          max_code_i,
   input  logic                      cmd_valid_i,
   input  logic [2:0]                cmd_ch_i,
   input  logic [1:0]                cmd_mode_i,
   input  logic [ADC_W-1:0]          cmd_target_i,
   input  logic [ADC_W-1:0]          cmd_hyst_i,
   output logic [CHANNELS-1:0]       heater_en_o,
   output logic [CHANNELS-1:0]       at_target_o,
   output logic [CHANNELS-1:0]       fault_o
);

   localparam logic [2:0] ST_OFF    = 3'd0;
   localparam logic [2:0] ST_SETTLE = 3'd1;
   localparam logic [2:0] ST_HEAT   = 3'd2;
   localparam logic [2:0] ST_DONE   = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;
   localparam logic [2:0] ST_FAULT  = 3'd5;

   localparam logic [1:0] MODE_OFF  = 2'd0;
   localparam logic [1:0] MODE_ONCE = 2'd1;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   localparam int CNT_W = $clog2(SETTLE_CYC + 1);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [ADC_W-1:0]        adc;
      logic [ADC_W-1:0]        filt_q, filt_d;
      logic [ADC_W-1:0]        target_q, target_d;
      logic [ADC_W-1:0]        hyst_q, hyst_d;
      logic [1:0]              mode_q, mode_d;
      logic [2:0]              st_q, st_d;
      logic [CNT_W-1:0]        cnt_q, cnt_d;
      logic                    heat_q, heat_d;
      logic                    at_q, at_d;
      logic                    fault_q, fault_d;
      logic signed [ADC_W+1:0] diff, step, sum;
      logic [ADC_W:0]          band_top;
      logic                    cmd_hit, cmd_off, over_temp, trip;

      assign adc       = adc_code_i[g*ADC_W +: ADC_W];
      assign cmd_hit   = cmd_valid_i && (cmd_ch_i == 3'(g));
      assign cmd_off   = (cmd_mode_i == MODE_OFF) || (cmd_mode_i == MODE_RSVD);
      assign over_temp = (st_q != ST_OFF) && (filt_q < max_code_i);
      assign band_top  = {1'b0, target_q} + {1'b0, hyst_q};

      // Extra headroom bit keeps the signed difference and sum exact before saturation.
      always_comb begin
         diff = $signed({2'b00, adc}) - $signed({2'b00, filt_q});
         step = diff >>> FILT_SHIFT;
         sum  = $signed({2'b00, filt_q}) + step;
         if (sum < 0) begin
            filt_d = '0;
         end else if (sum > $signed({2'b00, {ADC_W{1'b1}}})) begin
            filt_d = '1;
         end else begin
            filt_d = sum[ADC_W-1:0];
         end
      end

`ifdef HEATER_RUNAWAY_EN
      localparam int RUN_W = $clog2(RUNAWAY_CYC + 1);
      logic [RUN_W-1:0] run_q, run_d;
      logic             heating;

      assign heating = heat_q && ((st_q == ST_HEAT) || (st_q == ST_HOLD));
      assign run_d   = heating ? run_q + 1'b1 : '0;
      // Trip on the edge that closes the RUNAWAY_CYC-th consecutive heater-on cycle.
      assign trip    = over_temp || (heating && (run_q == RUN_W'(RUNAWAY_CYC - 1)));

      always_ff @(posedge clk_i) begin
         if (!rst_n_i) begin
            run_q <= '0;
         end else begin
            run_q <= run_d;
         end
      end
`else
      assign trip = over_temp;
`endif

      always_comb begin
         st_d     = st_q;
         cnt_d    = cnt_q;
         target_d = target_q;
         hyst_d   = hyst_q;
         mode_d   = mode_q;
         heat_d   = heat_q;
         at_d     = at_q;
         fault_d  = fault_q;
         if (cmd_hit && cmd_off) begin
            target_d = cmd_target_i;
            hyst_d   = cmd_hyst_i;
            mode_d   = cmd_mode_i;
            st_d     = ST_OFF;
            cnt_d    = '0;
            heat_d   = 1'b0;
            at_d     = 1'b0;
            fault_d  = 1'b0;
         end else if (trip) begin
            st_d    = ST_FAULT;
            heat_d  = 1'b0;
            at_d    = 1'b0;
            fault_d = 1'b1;
         end else if (cmd_hit && (st_q != ST_FAULT)) begin
            target_d = cmd_target_i;
            hyst_d   = cmd_hyst_i;
            mode_d   = cmd_mode_i;
            st_d     = ST_SETTLE;
            cnt_d    = CNT_W'(SETTLE_CYC);
            heat_d   = 1'b0;
            at_d     = 1'b0;
         end else begin
            case (st_q)
               ST_SETTLE: begin
                  heat_d = 1'b0;
                  if (cnt_q <= CNT_W'(1)) begin
                     st_d  = (mode_q == MODE_ONCE) ? ST_HEAT : ST_HOLD;
                     cnt_d = '0;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               ST_HEAT: begin
                  if (filt_q <= target_q) begin
                     heat_d = 1'b0;
                     at_d   = 1'b1;
                     st_d   = ST_DONE;
                  end else begin
                     heat_d = 1'b1;
                  end
               end
               ST_DONE: begin
                  heat_d = 1'b0;
                  at_d   = 1'b1;
               end
               ST_HOLD: begin
                  // Inside the band the heater keeps its previous drive.
                  if (filt_q <= target_q) begin
                     heat_d = 1'b0;
                     at_d   = 1'b1;
                  end else if ({1'b0, filt_q} >= band_top) begin
                     heat_d = 1'b1;
                     at_d   = 1'b0;
                  end
               end
               ST_FAULT: begin
                  heat_d  = 1'b0;
                  fault_d = 1'b1;
               end
               default: begin
                  heat_d = 1'b0;
                  at_d   = 1'b0;
               end
            endcase
         end
      end

      always_ff @(posedge clk_i) begin
         if (!rst_n_i) begin
            filt_q   <= '1;
            target_q <= '0;
            hyst_q   <= '0;
            mode_q   <= MODE_OFF;
            st_q     <= ST_OFF;
            cnt_q    <= '0;
            heat_q   <= 1'b0;
            at_q     <= 1'b0;
            fault_q  <= 1'b0;
         end else begin
            filt_q   <= filt_d;
            target_q <= target_d;
            hyst_q   <= hyst_d;
            mode_q   <= mode_d;
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            heat_q   <= heat_d;
            at_q     <= at_d;
            fault_q  <= fault_d;
         end
      end

      assign heater_en_o[g] = heat_q;
      assign at_target_o[g] = at_q;
      assign fault_o[g]     = fault_q;
   end

endmodule
